// File: rtl/dmem_bus_responder.sv
// ---------------------------------------------------------------------------
// dmem_bus_responder
//
// Data-memory responder sitting behind the M stage of the 5-stage core. It
// takes the raw M-stage access (unshifted byte write-enable pattern or a load
// request), lane-aligns it onto a 32-bit word bus, runs the req/gnt then
// rvalid handshake and holds the pipeline with core_stall until it is done.
//
// Ports:
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   core_addr      : M-stage byte address
//   core_wdata     : store data, right-justified
//   core_w_en      : unshifted store byte pattern (0000 = no store)
//   core_rd        : load request
//   core_stall     : freeze the core pipeline
//   core_rdata     : last word returned by a successful bus read, unshifted
//   misalign_err   : one-cycle pulse, misaligned store dropped
//   bus_err        : one-cycle pulse, access timed out
//   bus_req        : bus request (only while in REQ)
//   bus_we         : 1 = write
//   bus_addr       : word address of the captured access
//   bus_be         : byte lanes of the captured access
//   bus_wdata      : lane-aligned store data
//   bus_gnt        : request accepted this cycle
//   bus_rvalid     : bus_rdata valid this cycle
//   bus_rdata      : read word
// ---------------------------------------------------------------------------
module dmem_bus_responder #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   input  logic [3:0]  core_w_en,
   input  logic        core_rd,
   output logic        core_stall,
   output logic [31:0] core_rdata,
   output logic        misalign_err,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   state_t      state_next;
   logic [7:0]  cnt;
   logic        is_store;
   logic        access_present;
   logic        misaligned;
   logic        timeout_hit;
   logic        start_access;
   logic        read_done;
   logic [1:0]  offset;
   logic [7:0]  be_shift;
   logic [31:0] wdata_shift;

   // Decode of the incoming M-stage access. A store wins over a load when
   // both are requested. Only sh/sw shapes can be misaligned; any other
   // nonzero pattern is shifted as-is and lanes past byte 3 fall off.
   // timeout_hit uses >= so a late grant that moves a read into WAIT_R on
   // the last allowed cycle still times out on the following cycle.
   always_comb begin
      is_store       = |core_w_en;
      access_present = core_rd | is_store;
      misaligned     = is_store &&
                       (((core_w_en == 4'b0011) && core_addr[0]) ||
                        ((core_w_en == 4'b1111) && (core_addr[1:0] != 2'b00)));
      offset         = core_addr[1:0];
      be_shift       = {4'b0000, core_w_en} << offset;
      wdata_shift    = core_wdata << {offset, 3'b000};
      timeout_hit    = cnt >= TIMEOUT_LAST;
      start_access   = (state == IDLE) && access_present && !misaligned;
      read_done      = ((state == REQ) && bus_gnt && !bus_we && bus_rvalid) ||
                       ((state == WAIT_R) && bus_rvalid);
   end

   // State register. Reset is asynchronous so bus_req, which is decoded
   // from the state, drops the moment rst rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. DONE always returns to IDLE so the request the core
   // is still presenting during DONE is not captured a second time.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (access_present && !misaligned) begin
               state_next = REQ;
            end
         end
         REQ: begin
            if (bus_gnt) begin
               state_next = (bus_we || bus_rvalid) ? DONE : WAIT_R;
            end else if (timeout_hit) begin
               state_next = DONE;
            end
         end
         WAIT_R: begin
            if (bus_rvalid || timeout_hit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output decode. In IDLE the stall is raised combinationally so the core
   // freezes in the same cycle it presents an access; a misaligned store is
   // reported instead and the core moves on. The error pulse only fires when
   // the awaited event is absent on the final allowed cycle.
   always_comb begin
      bus_req      = 1'b0;
      core_stall   = 1'b0;
      misalign_err = 1'b0;
      bus_err      = 1'b0;
      case (state)
         IDLE: begin
            core_stall   = access_present && !misaligned;
            misalign_err = misaligned;
         end
         REQ: begin
            bus_req    = 1'b1;
            core_stall = 1'b1;
            bus_err    = !bus_gnt && timeout_hit;
         end
         WAIT_R: begin
            core_stall = 1'b1;
            bus_err    = !bus_rvalid && timeout_hit;
         end
         default: begin
            core_stall = 1'b0;
         end
      endcase
   end

   // Datapath registers: the bus side is captured once when the access is
   // accepted and then held stable for the whole handshake. Loads keep the
   // previous bus_wdata. core_rdata only changes on a successful read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_addr   <= 32'h0;
         bus_be     <= 4'h0;
         bus_wdata  <= 32'h0;
         bus_we     <= 1'b0;
         cnt        <= 8'h0;
         core_rdata <= 32'h0;
      end else begin
         if (start_access) begin
            bus_addr <= {core_addr[31:2], 2'b00};
            bus_we   <= is_store;
            cnt      <= 8'h0;
            if (is_store) begin
               bus_be    <= be_shift[3:0];
               bus_wdata <= wdata_shift;
            end else begin
               bus_be    <= 4'hF;
            end
         end else if ((state == REQ) || (state == WAIT_R)) begin
            cnt <= cnt + 8'h1;
         end
         if (read_done) begin
            core_rdata <= bus_rdata;
         end
      end
   end

endmodule

// File: tb/tb_dmem_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_bus_responder
//
// Bench for dmem_bus_responder. The main instance uses the default timeout
// and is driven with directed and random accesses; a second instance with
// TIMEOUT=4 exercises the abort path. Expected bus lanes, stall lengths and
// read data come from a small model of the access rules kept here.
// ---------------------------------------------------------------------------
module tb_dmem_bus_responder;

   logic        clk = 1'b0;
   logic        rst;

   logic [31:0] core_addr, core_wdata, core_rdata, bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  core_w_en, bus_be;
   logic        core_rd, core_stall, misalign_err, bus_err, bus_req, bus_we;
   logic        bus_gnt, bus_rvalid;

   logic [31:0] t_core_addr, t_core_wdata, t_core_rdata, t_bus_addr, t_bus_wdata, t_bus_rdata;
   logic [3:0]  t_core_w_en, t_bus_be;
   logic        t_core_rd, t_core_stall, t_misalign_err, t_bus_err, t_bus_req, t_bus_we;
   logic        t_bus_gnt, t_bus_rvalid;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] model_rdata = 32'h0;
   logic [31:0] t_model_rdata = 32'h0;

   always #5 clk = ~clk;

   dmem_bus_responder dut (
      .clk(clk), .rst(rst),
      .core_addr(core_addr), .core_wdata(core_wdata), .core_w_en(core_w_en),
      .core_rd(core_rd), .core_stall(core_stall), .core_rdata(core_rdata),
      .misalign_err(misalign_err), .bus_err(bus_err), .bus_req(bus_req),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata)
   );

   dmem_bus_responder #(.TIMEOUT(4)) dut_to (
      .clk(clk), .rst(rst),
      .core_addr(t_core_addr), .core_wdata(t_core_wdata), .core_w_en(t_core_w_en),
      .core_rd(t_core_rd), .core_stall(t_core_stall), .core_rdata(t_core_rdata),
      .misalign_err(t_misalign_err), .bus_err(t_bus_err), .bus_req(t_bus_req),
      .bus_we(t_bus_we), .bus_addr(t_bus_addr), .bus_be(t_bus_be),
      .bus_wdata(t_bus_wdata), .bus_gnt(t_bus_gnt), .bus_rvalid(t_bus_rvalid),
      .bus_rdata(t_bus_rdata)
   );

   // One comparison: counts it, and on a mismatch counts and reports it.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Step to just after the next rising edge, where inputs are changed.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Drive nothing for one cycle on the main instance and confirm it is quiet.
   task automatic idleCycle();
      nextCycle();
      core_addr = 32'h0; core_wdata = 32'h0; core_w_en = 4'h0; core_rd = 1'b0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      #1;
      checkOutput("idle_stall", core_stall, 1'b0);
      checkOutput("idle_req", bus_req, 1'b0);
   endtask

   // One access on the main instance. The responder grants gnt_delay cycles
   // into the request and returns data rv_delay cycles after the grant
   // (0 = same cycle). Expectations come from the lane/stall rules.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] w_en, input logic rd,
                                input int gnt_delay, input int rv_delay,
                                input logic [31:0] rword);
      logic        is_store, present, mis, done;
      int          o, exp_stall, stalls;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      is_store  = (w_en != 4'h0);
      present   = is_store || rd;
      o         = int'(addr[1:0]);
      mis       = is_store && (((w_en == 4'b0011) && addr[0]) ||
                               ((w_en == 4'b1111) && (o != 0)));
      exp_be    = 4'hF;
      if (is_store) begin
         exp_be = 4'h0;
         for (int j = 0; j < 4; j++) begin
            if (w_en[j] && (j + o) < 4) exp_be[j + o] = 1'b1;
         end
      end
      exp_wdata = wdata << (8 * o);
      exp_stall = is_store ? gnt_delay + 2 : gnt_delay + rv_delay + 2;

      nextCycle();
      core_addr = addr; core_wdata = wdata; core_w_en = w_en; core_rd = rd;
      bus_gnt = 1'($urandom); bus_rvalid = 1'($urandom); bus_rdata = $urandom;
      #1;
      checkOutput("first_stall", core_stall, present && !mis);
      checkOutput("misalign_err", misalign_err, mis);
      checkOutput("first_req", bus_req, 1'b0);
      if (!present || mis) return;

      stalls = 1;
      done   = 1'b0;
      for (int c = 1; c <= 40 && !done; c++) begin
         nextCycle();
         bus_gnt    = (c == gnt_delay + 1);
         bus_rvalid = !is_store && (c == gnt_delay + 1 + rv_delay);
         bus_rdata  = bus_rvalid ? rword : $urandom;
         #1;
         if (c == 1) begin
            checkOutput("bus_addr", bus_addr, {addr[31:2], 2'b00});
            checkOutput("bus_be", {28'h0, bus_be}, {28'h0, exp_be});
            checkOutput("bus_we", bus_we, is_store);
            if (is_store) checkOutput("bus_wdata", bus_wdata, exp_wdata);
         end
         checkOutput("bus_req", bus_req, (c <= gnt_delay + 1));
         checkOutput("bus_err", bus_err, 1'b0);
         if (core_stall) stalls++;
         else done = 1'b1;
      end
      checkOutput("stall_bound", done, 1'b1);
      checkOutput("stall_cycles", stalls, exp_stall);
      if (!is_store) model_rdata = rword;
      checkOutput("core_rdata", core_rdata, model_rdata);
   endtask

   // One access on the TIMEOUT=4 instance. gnt_at/rv_at are cycle numbers
   // after the IDLE cycle (0 = never). With four allowed cycles in REQ plus
   // WAIT_R, a missing event errors on cycle 4 and DONE follows on cycle 5.
   task automatic toAccess(input logic [3:0] w_en, input int gnt_at, input int rv_at,
                           input int exp_done_at, input int exp_err_at,
                           input logic [31:0] rword, input logic takes_data);
      nextCycle();
      t_core_addr = 32'h0000_0080; t_core_wdata = 32'h1234_5678;
      t_core_w_en = w_en; t_core_rd = (w_en == 4'h0);
      t_bus_gnt = 1'b0; t_bus_rvalid = 1'b0; t_bus_rdata = 32'h0;
      #1;
      checkOutput("to_idle_stall", t_core_stall, 1'b1);
      for (int c = 1; c <= exp_done_at; c++) begin
         nextCycle();
         t_bus_gnt    = (c == gnt_at);
         t_bus_rvalid = (c == rv_at);
         t_bus_rdata  = t_bus_rvalid ? rword : $urandom;
         #1;
         checkOutput("to_bus_err", t_bus_err, (c == exp_err_at));
         checkOutput("to_stall", t_core_stall, (c < exp_done_at));
      end
      if (takes_data) t_model_rdata = rword;
      checkOutput("to_rdata", t_core_rdata, t_model_rdata);
      nextCycle();
      t_core_w_en = 4'h0; t_core_rd = 1'b0; t_bus_gnt = 1'b0; t_bus_rvalid = 1'b0;
      #1;
      checkOutput("to_after_stall", t_core_stall, 1'b0);
      checkOutput("to_after_req", t_bus_req, 1'b0);
   endtask

   // Stop a hung run with a report rather than spinning forever.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed no end expected end");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence followed by a random batch.
   initial begin
      rst = 1'b1;
      core_addr = 32'h0; core_wdata = 32'h0; core_w_en = 4'h0; core_rd = 1'b0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
      t_core_addr = 32'h0; t_core_wdata = 32'h0; t_core_w_en = 4'h0; t_core_rd = 1'b0;
      t_bus_gnt = 1'b0; t_bus_rvalid = 1'b0; t_bus_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      $display("[TB] reset state");
      checkOutput("rst_req", bus_req, 1'b0);
      checkOutput("rst_stall", core_stall, 1'b0);
      checkOutput("rst_we", bus_we, 1'b0);
      checkOutput("rst_addr", bus_addr, 32'h0);
      checkOutput("rst_be", {28'h0, bus_be}, 32'h0);
      checkOutput("rst_wdata", bus_wdata, 32'h0);
      checkOutput("rst_rdata", core_rdata, 32'h0);
      checkOutput("rst_errs", {misalign_err, bus_err}, 2'b00);
      idleCycle();

      $display("[TB] directed accesses");
      applyStimulus(32'h0000_1003, 32'h0000_00A5, 4'b0001, 1'b0, 0, 0, 32'h0);
      applyStimulus(32'h0000_0012, 32'h0000_BEEF, 4'b0011, 1'b0, 0, 0, 32'h0);
      applyStimulus(32'h0000_0011, 32'h0000_BEEF, 4'b0011, 1'b0, 0, 0, 32'h0);
      idleCycle();
      applyStimulus(32'h0000_0022, 32'hCAFE_F00D, 4'b1111, 1'b0, 0, 0, 32'h0);
      idleCycle();
      applyStimulus(32'h0000_0020, 32'h0, 4'b0000, 1'b1, 3, 2, 32'hDEAD_BEEF);
      applyStimulus(32'h0000_0024, 32'h0, 4'b0000, 1'b1, 0, 0, 32'h0BAD_F00D);
      applyStimulus(32'h0000_0028, 32'h1122_3344, 4'b1111, 1'b1, 1, 0, 32'h0);
      applyStimulus(32'h0000_0030, 32'h0, 4'b0000, 1'b0, 0, 0, 32'h0);

      $display("[TB] reset during request");
      nextCycle();
      core_addr = 32'h0000_0040; core_rd = 1'b1; core_w_en = 4'h0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      nextCycle();
      #1;
      checkOutput("req_before_rst", bus_req, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("req_on_rst", bus_req, 1'b0);
      core_rd = 1'b0;
      #1;
      checkOutput("stall_on_rst", core_stall, 1'b0);
      nextCycle();
      rst = 1'b0;
      model_rdata = 32'h0;
      t_model_rdata = 32'h0;
      #1;
      checkOutput("rdata_after_rst", core_rdata, 32'h0);
      checkOutput("addr_after_rst", bus_addr, 32'h0);
      idleCycle();

      $display("[TB] timeout instance");
      toAccess(4'b0000, 1, 1, 2, 0, 32'h1357_9BDF, 1'b1);
      toAccess(4'b0000, 0, 0, 5, 4, 32'h0, 1'b0);
      toAccess(4'b1111, 4, 0, 5, 0, 32'h0, 1'b0);
      toAccess(4'b0000, 1, 0, 5, 4, 32'h0, 1'b0);
      toAccess(4'b0000, 1, 4, 5, 0, 32'h2468_ACE0, 1'b1);

      $display("[TB] random accesses");
      for (int n = 0; n < 40; n++) begin
         logic [3:0] w;
         case ($urandom_range(4, 0))
            0:       w = 4'b0000;
            1:       w = 4'b0001;
            2:       w = 4'b0011;
            3:       w = 4'b1111;
            default: w = 4'($urandom);
         endcase
         applyStimulus($urandom, $urandom, w, 1'($urandom),
                       int'($urandom_range(3, 0)), int'($urandom_range(2, 0)), $urandom);
      end
      idleCycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
